// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period states, control-period codes and guard codes.
package tmds_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } period_t;

  // Per-channel control pairs. Green carries {CTL1,CTL0}; red carries {CTL3,CTL2}.
  localparam logic [1:0] CTL_IDLE      = 2'b00;
  localparam logic [1:0] PRE_CTL_GREEN = 2'b01;  // CTL0=1, CTL1=0
  localparam logic [1:0] PRE_CTL_RED   = 2'b00;  // CTL2=0, CTL3=0

  // Video guard-band codes substituted by the output mux.
  localparam logic [9:0] GUARD_CODE_BR = 10'b1011001100;
  localparam logic [9:0] GUARD_CODE_G  = 10'b0100110011;

  // Control-period symbols, shared with tmds_encoder.
  localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

  // One pipeline slot of the raw pixel stream.
  typedef struct packed {
    logic       active;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pix_t;

  function automatic logic [9:0] ctrl_code(input logic [1:0] ctl);
    case (ctl)
      2'b00:   return CTRL_CODE_00;
      2'b01:   return CTRL_CODE_01;
      2'b10:   return CTRL_CODE_10;
      default: return CTRL_CODE_11;
    endcase
  endfunction

  function automatic logic [9:0] guard_code(input logic is_green);
    return is_green ? GUARD_CODE_G : GUARD_CODE_BR;
  endfunction

endpackage

// File: rtl/tmds_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
module tmds_delay_line #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 27
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per clock; reset empties every stage.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/tmds_period_scheduler.sv
// Sequences CTRL / PREAMBLE / GUARD / VIDEO periods for the three TMDS encoders.
// The pixel stream is delayed by PREAMBLE_LEN+GUARD_LEN stages plus an output
// register so that the preamble and guard band fit in front of each line.
module tmds_period_scheduler
  import tmds_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int MIN_BLANK    = 12
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       hdmi_en_in,
  input  logic       active_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic       ve_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic [1:0] ctrl_red_out,
  output logic [1:0] ctrl_green_out,
  output logic [1:0] ctrl_blue_out,
  output logic       guard_sel_out,
  output logic       short_blank_out
);

  localparam int         D           = PREAMBLE_LEN + GUARD_LEN;
  localparam logic [4:0] MIN_BLANK_C = 5'(MIN_BLANK);
  localparam logic [3:0] PRE_LOAD    = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] GUARD_LOAD  = 4'(GUARD_LEN - 1);

  pix_t       pix_in;
  pix_t       tap;
  period_t    state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [4:0] blank_cnt_q, blank_cnt_d;
  logic       active_prev_q;
  logic       hsync_q, vsync_q;
  logic [7:0] red_q, green_q, blue_q;
  logic       guard_sel_q;
  logic       short_blank_q;
  logic       rise;
  logic       blank_ok;

  assign pix_in = {active_in, hsync_in, vsync_in, red_in, green_in, blue_in};

  tmds_delay_line #(
    .DEPTH(D),
    .WIDTH($bits(pix_t))
  ) u_delay (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .d_in    (pix_in),
    .q_out   (tap)
  );

  // Line-start detection and saturating count of the preceding blank run.
  always_comb begin
    rise        = active_in & ~active_prev_q;
    blank_ok    = (blank_cnt_q >= MIN_BLANK_C);
    blank_cnt_d = blank_cnt_q;
    if (active_in)                blank_cnt_d = '0;
    else if (blank_cnt_q != 5'd31) blank_cnt_d = blank_cnt_q + 5'd1;
  end

  // Period FSM next state; hdmi_en_in only matters at the CTRL decision.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      CTRL: begin
        if (rise && hdmi_en_in && blank_ok) begin
          state_d = PREAMBLE;
          phase_d = PRE_LOAD;
        end else if (tap.active) begin
          state_d = VIDEO;
        end
      end
      PREAMBLE: begin
        if (phase_q == 4'd0) begin
          state_d = GUARD;
          phase_d = GUARD_LOAD;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      GUARD: begin
        if (phase_q == 4'd0) begin
          state_d = VIDEO;
          phase_d = '0;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      VIDEO: begin
        if (!tap.active) state_d = CTRL;
      end
      default: state_d = CTRL;
    endcase
  end

  // State, counters and the output stage of the pixel pipeline.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= CTRL;
      phase_q       <= '0;
      blank_cnt_q   <= '0;
      active_prev_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      guard_sel_q   <= 1'b0;
      short_blank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      blank_cnt_q   <= blank_cnt_d;
      active_prev_q <= active_in;
      hsync_q       <= tap.hsync;
      vsync_q       <= tap.vsync;
      red_q         <= tap.red;
      green_q       <= tap.green;
      blue_q        <= tap.blue;
      // Guard select trails GUARD by one cycle to match the encoder latency.
      guard_sel_q   <= (state_q == GUARD);
      short_blank_q <= rise & hdmi_en_in & ~blank_ok;
    end
  end

  // Encoder-facing outputs decoded from the current period.
  always_comb begin
    ve_out          = (state_q == VIDEO);
    red_out         = ve_out ? red_q   : '0;
    green_out       = ve_out ? green_q : '0;
    blue_out        = ve_out ? blue_q  : '0;
    ctrl_blue_out   = {vsync_q, hsync_q};
    ctrl_green_out  = CTL_IDLE;
    ctrl_red_out    = CTL_IDLE;
    if (state_q == PREAMBLE || state_q == GUARD) begin
      ctrl_green_out = PRE_CTL_GREEN;
      ctrl_red_out   = PRE_CTL_RED;
    end
    guard_sel_out   = guard_sel_q;
    short_blank_out = short_blank_q;
  end

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Scoreboard bench for tmds_period_scheduler: a cycle-indexed reference model
// marks preamble/guard windows from line starts and queues expected outputs.
module tb_tmds_period_scheduler;

  localparam int LAT = 11;     // input-to-output latency in cycles
  localparam int PRE = 8;
  localparam int GRD = 2;
  localparam int MINB = 12;
  localparam int N = 4096;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       hdmi_en_in = 1'b0;
  logic       active_in = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [7:0] red_in = '0, green_in = '0, blue_in = '0;
  logic       ve_out;
  logic [7:0] red_out, green_out, blue_out;
  logic [1:0] ctrl_red_out, ctrl_green_out, ctrl_blue_out;
  logic       guard_sel_out, short_blank_out;

  tmds_period_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .hdmi_en_in(hdmi_en_in),
    .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .ve_out(ve_out), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .ctrl_red_out(ctrl_red_out), .ctrl_green_out(ctrl_green_out),
    .ctrl_blue_out(ctrl_blue_out), .guard_sel_out(guard_sel_out),
    .short_blank_out(short_blank_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       ve;
    logic [7:0] r, g, b;
    logic [1:0] cr, cg, cb;
    logic       gsel, sblk;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: input history and period marks, indexed by cycle since reset.
  bit         m_act[N];
  bit         m_hs[N];
  bit         m_vs[N];
  logic [23:0] m_pix[N];
  bit         m_pre[N];
  bit         m_grd[N];
  bit         m_gsel[N];
  bit         m_sblk[N];
  int         idx;
  int         blank_run;

  function automatic obs_t observe();
    obs_t a;
    a = {ve_out, red_out, green_out, blue_out, ctrl_red_out, ctrl_green_out,
         ctrl_blue_out, guard_sel_out, short_blank_out};
    return a;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_hs[i] = 0; m_vs[i] = 0; m_pix[i] = '0;
      m_pre[i] = 0; m_grd[i] = 0; m_gsel[i] = 0; m_sblk[i] = 0;
    end
    idx = 0;
    blank_run = 0;
  endtask

  // Expected outputs for cycle c: data is the input from c-LAT, periods come from marks.
  function automatic obs_t expect_for(int c);
    obs_t e;
    int   src;
    e   = '0;
    src = c - LAT;
    if (src >= 0) begin
      e.ve = m_act[src];
      e.cb = {m_vs[src], m_hs[src]};
      if (m_act[src]) {e.r, e.g, e.b} = m_pix[src];
    end
    if (m_pre[c] || m_grd[c]) e.cg = 2'b01;
    e.gsel = m_gsel[c];
    e.sblk = m_sblk[c];
    return e;
  endfunction

  // Record one input cycle and mark the periods that a line start implies.
  task automatic model_apply(bit act, bit hs, bit vs, logic [23:0] pix, bit hdmi);
    bit rise;
    m_act[idx] = act; m_hs[idx] = hs; m_vs[idx] = vs; m_pix[idx] = pix;
    rise = act && (idx == 0 || !m_act[idx-1]);
    if (rise && hdmi) begin
      if (blank_run >= MINB) begin
        for (int k = 1; k <= PRE; k++) m_pre[idx+k] = 1;
        for (int k = PRE + 1; k <= PRE + GRD; k++) m_grd[idx+k] = 1;
        m_gsel[idx+PRE+GRD] = 1;
        m_gsel[idx+PRE+GRD+1] = 1;
      end else begin
        m_sblk[idx+1] = 1;
      end
    end
    blank_run = act ? 0 : (blank_run < 31 ? blank_run + 1 : 31);
    idx++;
  endtask

  task automatic drive(bit act, bit hs, bit vs, logic [23:0] pix, bit hdmi);
    rec_t r;
    @(posedge clk_in);
    #1;
    if (idx >= N - 16) begin
      $display("FAIL model-capacity: idx=%0d, required < %0d", idx, N - 16);
      $fatal(1, "model history exhausted");
    end
    rst_n_in = 1'b1;
    r.cyc = idx;
    r.o   = expect_for(idx);
    exp_q.push_back(r);
    active_in  = act;
    hsync_in   = hs;
    vsync_in   = vs;
    {red_in, green_in, blue_in} = pix;
    hdmi_en_in = hdmi;
    model_apply(act, hs, vs, pix, hdmi);
  endtask

  task automatic check_zero(string name);
    obs_t a;
    a = observe();
    n_checks++;
    if (a !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h, required all zero", name, a);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    exp_q.delete();
    #1;
    check_zero("reset-immediate");
    repeat (2) @(posedge clk_in);
    model_clear();
  endtask

  task automatic blank(int n, bit hdmi);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), hdmi);
  endtask

  // One active line; drop_at clears hdmi from that offset, rst_at resets instead.
  task automatic line(int len, bit hdmi, bit seq, int drop_at, int rst_at);
    logic [23:0] pix;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      pix = seq ? {8'(i), 8'(i), 8'(i)} : 24'($urandom);
      drive(1'b1, 1'($urandom), 1'($urandom), pix,
            (drop_at >= 0 && i >= drop_at) ? 1'b0 : hdmi);
    end
  endtask

  // Monitor: one expected record per output cycle while out of reset.
  always @(negedge clk_in) begin
    rec_t e;
    obs_t a;
    if (rst_n_in && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = observe();
      n_checks++;
      if (a !== e.o) begin
        n_fail++;
        $display("FAIL cycle %0d: got ve=%b rgb=%h/%h/%h ctl_r/g/b=%b/%b/%b gsel=%b sblk=%b, expected ve=%b rgb=%h/%h/%h ctl_r/g/b=%b/%b/%b gsel=%b sblk=%b",
                 e.cyc, a.ve, a.r, a.g, a.b, a.cr, a.cg, a.cb, a.gsel, a.sblk,
                 e.o.ve, e.o.r, e.o.g, e.o.b, e.o.cr, e.o.cg, e.o.cb, e.o.gsel, e.o.sblk);
      end else begin
        $display("cycle %0d ok: ve=%b rgb=%h/%h/%h ctl_g=%b ctl_b=%b gsel=%b sblk=%b",
                 e.cyc, a.ve, a.r, a.g, a.b, a.cg, a.cb, a.gsel, a.sblk);
      end
    end
  end

  initial begin
    bit h;
    model_clear();
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset-initial");

    blank(20, 1'b1); line(16, 1'b1, 1'b1, -1, -1);   // HDMI line, pixel = index
    blank(20, 1'b0); line(16, 1'b0, 1'b1, -1, -1);   // DVI, same stimulus
    blank(20, 1'b1); line(5, 1'b1, 1'b0, -1, -1);
    blank(11, 1'b1); line(6, 1'b1, 1'b0, -1, -1);    // blank one short of minimum
    blank(12, 1'b1); line(6, 1'b1, 1'b0, -1, -1);    // exactly minimum blank
    blank(14, 1'b1); line(10, 1'b1, 1'b0, 3, -1);    // hdmi drops at tr+3
    blank(15, 1'b0); line(8, 1'b0, 1'b0, -1, -1);    // following line is DVI
    blank(13, 1'b1); line(1, 1'b1, 1'b0, -1, -1);    // single-cycle line
    blank(3, 1'b1);  line(2, 1'b1, 1'b0, -1, -1);    // short blank again
    blank(20, 1'b1); line(12, 1'b1, 1'b0, -1, 4);    // reset mid-preamble
    blank(30, 1'b1); line(4, 1'b1, 1'b0, -1, -1);

    for (int n = 0; n < 60; n++) begin
      h = ($urandom_range(0, 3) != 0);
      blank($urandom_range(1, 24), h);
      line($urandom_range(1, 20), h, 1'b0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1, -1);
    end
    blank(20, 1'b1);

    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
